// File: rtl/turn_timer_digits.sv
//------------------------------------------------------------------------------
// turn_timer_digits : per-turn BCD seconds countdown with frame-stable display
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module turn_timer_digits #(
  parameter int unsigned TICK_DIV = 50000000,
  parameter int unsigned WARN_SEC = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [6:0] load_sec,
  input  logic       stop,
  input  logic       hold,
  input  logic       frame_start,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       warn,
  output logic       running,
  output logic       expired
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] C_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} state_t;

  state_t        r_state, w_next;
  logic [3:0]    r_cnt_t, r_cnt_o, w_cnt_t, w_cnt_o;
  logic [PW-1:0] r_presc, w_presc;
  logic          w_exp;

  logic [6:0] w_clamp;
  logic [3:0] w_load_t, w_load_o;
  logic [6:0] w_cnt_bin;

  assign w_clamp   = (load_sec > 7'd99) ? 7'd99 : load_sec;
  assign w_load_t  = 4'(w_clamp / 7'd10);
  assign w_load_o  = 4'(w_clamp % 7'd10);
  assign w_cnt_bin = 7'(r_cnt_t) * 7'd10 + 7'(r_cnt_o);

  always_comb begin
    w_next  = r_state;
    w_cnt_t = r_cnt_t;
    w_cnt_o = r_cnt_o;
    w_presc = r_presc;
    w_exp   = 1'b0;
    if (start) begin
      w_cnt_t = w_load_t;
      w_cnt_o = w_load_o;
      w_presc = '0;
      if (w_clamp == 7'd0) begin
        w_next = DONE;
        // Back-to-back zero loads must not stretch the timeout pulse.
        w_exp  = ~expired;
      end else begin
        w_next = RUN;
      end
    end else if (stop) begin
      w_cnt_t = 4'd0;
      w_cnt_o = 4'd0;
      w_presc = '0;
      w_next  = IDLE;
    end else begin
      case (r_state)
        RUN: begin
          if (hold) begin
            w_next = HOLD;
          end else if (r_presc == C_LAST) begin
            w_presc = '0;
            if (w_cnt_bin <= 7'd1) begin
              w_cnt_t = 4'd0;
              w_cnt_o = 4'd0;
              w_next  = DONE;
              w_exp   = 1'b1;
            end else if (r_cnt_o == 4'd0) begin
              w_cnt_o = 4'd9;
              w_cnt_t = r_cnt_t - 4'd1;
            end else begin
              w_cnt_o = r_cnt_o - 4'd1;
            end
          end else begin
            w_presc = r_presc + PW'(1);
          end
        end
        HOLD: begin
          if (!hold) w_next = RUN;
        end
        default: begin
          w_presc = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt_t <= 4'd0;
      r_cnt_o <= 4'd0;
      r_presc <= '0;
      running <= 1'b0;
      expired <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt_t <= w_cnt_t;
      r_cnt_o <= w_cnt_o;
      r_presc <= w_presc;
      running <= (w_next == RUN) || (w_next == HOLD);
      expired <= w_exp;
    end
  end

  // Display samples the pre-edge count so it stays constant for a whole frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      tens <= 4'd0;
      ones <= 4'd0;
      warn <= 1'b0;
    end else if (frame_start) begin
      tens <= r_cnt_t;
      ones <= r_cnt_o;
      warn <= (w_cnt_bin != 7'd0) && (32'(w_cnt_bin) <= WARN_SEC);
    end
  end

endmodule

`default_nettype wire

// File: doc/turn_timer_digits.md
Name: turn_timer_digits

Overview:
- Per-turn countdown timer for the UNO game; limits how long a player may take to act.
- Counts whole seconds down from a loaded value (0-99) in BCD.
- Presents frame-stable tens/ones digits that feed the seven-segment pixel overlay directly downstream of this block.
- Flags low time for highlighting and pulses on timeout so the game controller can force a draw/pass.

Parameters:
- TICK_DIV, 50000000, clk cycles per second tick (50 MHz board clock); benches use small values.
- WARN_SEC, 5, warn asserts while remaining seconds <= WARN_SEC and > 0.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- start  input  1  one-cycle pulse: load load_sec and begin counting
- load_sec  input  7  initial seconds, binary; values > 99 clamp to 99
- stop  input  1  one-cycle pulse: abort, clear count, go idle
- hold  input  1  level: freeze countdown while high
- frame_start  input  1  one-cycle pulse at start of each VGA frame (vertical blank)
- tens  output  4  displayed tens digit, BCD 0-9
- ones  output  4  displayed ones digit, BCD 0-9
- warn  output  1  displayed low-time flag
- running  output  1  high in RUN or HOLD
- expired  output  1  one-cycle timeout pulse

Behaviour:
- Reset: state IDLE; internal count 00; prescaler 0; tens=0, ones=0, warn=0, running=0, expired=0.
- Internal state: 2-digit BCD count (cnt_t, cnt_o), prescaler 0..TICK_DIV-1, FSM {IDLE, RUN, HOLD, DONE}.
- Priority each cycle: rst > start > stop > hold > tick.
- start, any state:
  - Clamped load_sec is converted to BCD into the count; prescaler cleared.
  - Next state RUN, or DONE if the clamped value is 0.
  - For a zero load, expired pulses in the cycle after start.
- stop, any state: count 00, prescaler 0, state IDLE. No expired pulse.
- RUN:
  - Prescaler increments each cycle. A tick occurs when prescaler == TICK_DIV-1; prescaler then wraps to 0.
  - On tick with count == 01: count 00, state DONE, expired=1 in the next cycle only.
  - On tick with count > 01: BCD decrement. If ones == 0, ones becomes 9 and tens decrements; otherwise ones decrements. The count never leaves the range 00-99.
  - hold=1 (no start/stop): go to HOLD in the same edge; prescaler keeps its value; no tick that cycle.
- HOLD:
  - Prescaler and count frozen.
  - hold=0 returns to RUN; counting resumes from the saved prescaler value, so no partial second is lost or repeated.
- IDLE and DONE: prescaler held at 0; hold ignored; state changes only on start or stop. running=0.
- running is registered from the next state: it goes high the cycle after start, low the cycle after a stop or timeout.
- expired is a registered one-cycle pulse. It never asserts two cycles in a row. It is not re-asserted while remaining in DONE.
- Display update:
  - tens, ones and warn are registered and update only on frame_start. They sample the count value present in that cycle; warn is computed from that same value.
  - The display never changes mid-frame. Latency from a count change to the display is up to one frame.
  - frame_start coinciding with a tick samples the pre-tick count.
  - frame_start coinciding with start samples the pre-load count.
- warn = (count != 0) and (count <= WARN_SEC), evaluated on the sampled count.
- reset mid-operation: all state returns to reset values on the next edge; a pending expired pulse is cancelled.

Test Plan:
- Reset/idle: TICK_DIV=4; rst 2 cycles, then frame_start pulses -> tens=0, ones=0, warn=0, running=0, expired never asserted.
- Load and borrow: start with load_sec=11, frame_start every cycle -> display sequence 11, 10, 09 at 4-cycle steps; the 10->09 step shows the ones=0 borrow. running=1 from the cycle after start.
- Timeout: load_sec=3 -> display 03/02/01/00; exactly one expired pulse the cycle after the 01->00 tick (12 cycles after start); state DONE; warn 1 at 03..01 and 0 at 00.
- Hold: load_sec=20; hold high for 10 cycles starting 2 cycles into a second -> count frozen during hold; the next tick occurs 2 cycles after hold falls; running stays 1.
- Clamp, zero load and stop: load_sec=120 -> display 99. Then start with load_sec=0 -> expired pulse next cycle, running=0. Then start with load_sec=50 and stop mid-count -> IDLE, display 00 at next frame_start, no expired.
- Frame gating: load_sec=30 with frame_start every 10 cycles -> tens/ones change only in cycles after frame_start. A start asserted together with frame_start leaves the display at the old value until the following frame_start.
